// File: rtl/jk_seq_pkg.sv
// Shared FSM state encoding and {J,K} mode constants for the JK count sequencer.
// Mode constants are packed as {j, k}.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_flip_flop.sv
// Single JK flip-flop cell with synchronous active-high reset.
// Output updates on the rising edge; there is no flow control.
module jk_flip_flop
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_count_sequencer.sv
// Run-to-terminal counter built on a bank of JK cells, with start/done handshake.
// Load lands one edge after request; count steps one per cycle in RUN; start/load ignored outside IDLE.
module jk_count_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             up,
    input  logic [WIDTH-1:0] terminal,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state;
    logic             dir_r;
    logic [WIDTH-1:0] term_r;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] tog;
    logic             acc;
    logic             step;
    logic             wrap_nxt;

    // A count step happens only in RUN when neither abort nor terminal stops it.
    assign step     = (state == RUN) && !abort && (q != term_r);
    assign wrap_nxt = step && (dir_r ? (&q) : (~|q));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        tog = '0;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i] = acc;
            acc    = acc & (dir_r ? q[i] : ~q[i]);
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (state == IDLE && load) begin
                {j[i], k[i]} = load_val[i] ? JK_SET : JK_RESET;
            end else if (step) begin
                {j[i], k[i]} = tog[i] ? JK_TOGGLE : JK_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dir_r  <= 1'b0;
            term_r <= '0;
            wrap   <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
            case (state)
                IDLE: begin
                    if (!load && start) begin
                        dir_r  <= up;
                        term_r <= terminal;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (q == term_r) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        jk_flip_flop u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[g]),
            .k   (k[g]),
            .q   (q[g])
        );
    end

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed bench for jk_count_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_jk_count_sequencer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             up;
    logic [WIDTH-1:0] terminal;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jk_count_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .up       (up),
        .terminal (terminal),
        .abort    (abort),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] load_val;
        logic       start;
        logic       up;
        logic [3:0] terminal;
        logic       abort;
        logic [3:0] exp_q;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
        up = 1'b0; terminal = '0; abort = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] eq, input logic eb,
                       input logic ed, input logic ew);
        n_checks++;
        if (q !== eq || busy !== eb || done !== ed || wrap !== ew) begin
            n_fail++;
            $display("FAIL %s: got q=%h busy=%b done=%b wrap=%b, expected q=%h busy=%b done=%b wrap=%b",
                     name, q, busy, done, wrap, eq, eb, ed, ew);
        end
    endtask

    task automatic add(input logic r, input logic ld, input logic [3:0] lv, input logic st,
                       input logic u, input logic [3:0] t, input logic ab,
                       input logic [3:0] eq, input logic eb, input logic ed, input logic ew);
        vec_t v;
        v.rst = r; v.load = ld; v.load_val = lv; v.start = st; v.up = u;
        v.terminal = t; v.abort = ab; v.exp_q = eq; v.exp_busy = eb;
        v.exp_done = ed; v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    // Load, then start a run with the given direction and terminal; checks the start edge.
    task automatic load_and_start(input string name, input logic [3:0] lv,
                                  input logic u, input logic [3:0] t);
        idle_inputs();
        load = 1'b1; load_val = lv;
        tick();
        chk({name, "_load"}, lv, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        start = 1'b1; up = u; terminal = t;
        tick();
        chk({name, "_start"}, lv, 1'b1, 1'b0, 1'b0);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        //   rst ld lv    st up term  ab   q     busy done wrap
        add(1, 0, 4'h0, 0, 0, 4'h0, 0,   4'h0, 0, 0, 0);
        add(0, 1, 4'h3, 0, 0, 4'h0, 0,   4'h3, 0, 0, 0);
        add(0, 0, 4'h0, 1, 1, 4'h7, 0,   4'h3, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h4, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h5, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h6, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h7, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h7, 0, 1, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h7, 0, 0, 0);
        add(0, 1, 4'h9, 1, 1, 4'hC, 0,   4'h9, 0, 0, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h9, 0, 0, 0);
        add(0, 1, 4'h5, 0, 0, 4'h0, 0,   4'h5, 0, 0, 0);
        add(0, 0, 4'h0, 1, 1, 4'h5, 0,   4'h5, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h5, 0, 1, 0);
        add(0, 0, 4'h0, 0, 0, 4'h0, 0,   4'h5, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; load = vecs[i].load; load_val = vecs[i].load_val;
            start = vecs[i].start; up = vecs[i].up; terminal = vecs[i].terminal;
            abort = vecs[i].abort;
            tick();
            chk($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_busy,
                vecs[i].exp_done, vecs[i].exp_wrap);
        end

        // Up run wrapping F->0 before reaching terminal 1.
        load_and_start("wup", 4'hE, 1'b1, 4'h1);
        tick(); chk("wup_f",    4'hF, 1, 0, 0);
        tick(); chk("wup_0",    4'h0, 1, 0, 1);
        tick(); chk("wup_1",    4'h1, 1, 0, 0);
        tick(); chk("wup_done", 4'h1, 0, 1, 0);
        tick(); chk("wup_idle", 4'h1, 0, 0, 0);

        // Down run wrapping 0->F.
        load_and_start("wdn", 4'h2, 1'b0, 4'hE);
        tick(); chk("wdn_1",    4'h1, 1, 0, 0);
        tick(); chk("wdn_0",    4'h0, 1, 0, 0);
        tick(); chk("wdn_f",    4'hF, 1, 0, 1);
        tick(); chk("wdn_e",    4'hE, 1, 0, 0);
        tick(); chk("wdn_done", 4'hE, 0, 1, 0);
        tick(); chk("wdn_idle", 4'hE, 0, 0, 0);

        // Abort at q=4: back to IDLE, q holds, no done.
        load_and_start("abt", 4'h0, 1'b1, 4'hA);
        for (int s = 1; s <= 4; s++) begin
            tick(); chk($sformatf("abt_q%0d", s), 4'(s), 1, 0, 0);
        end
        abort = 1'b1;
        tick(); chk("abt_edge", 4'h4, 0, 0, 0);
        abort = 1'b0;
        tick(); chk("abt_after", 4'h4, 0, 0, 0);

        // Reset mid-run at q=6, with start and abort asserted alongside.
        load_and_start("rst", 4'h0, 1'b1, 4'hA);
        for (int s = 1; s <= 6; s++) tick();
        chk("rst_q6", 4'h6, 1, 0, 0);
        rst = 1'b1; start = 1'b1; abort = 1'b1; load = 1'b1; load_val = 4'hB;
        tick(); chk("rst_edge", 4'h0, 0, 0, 0);
        idle_inputs();
        tick(); chk("rst_after", 4'h0, 0, 0, 0);

        // Start with new terminal/direction during RUN is ignored.
        load_and_start("ign", 4'h0, 1'b1, 4'h3);
        start = 1'b1; up = 1'b0; terminal = 4'h1; load = 1'b1; load_val = 4'hA;
        tick(); chk("ign_1", 4'h1, 1, 0, 0);
        idle_inputs();
        tick(); chk("ign_2",    4'h2, 1, 0, 0);
        tick(); chk("ign_3",    4'h3, 1, 0, 0);
        tick(); chk("ign_done", 4'h3, 0, 1, 0);
        tick(); chk("ign_idle", 4'h3, 0, 0, 0);

        // Earliest restart: start accepted in the first IDLE cycle after done.
        start = 1'b1; up = 1'b0; terminal = 4'h2;
        tick(); chk("rs_start", 4'h3, 1, 0, 0);
        idle_inputs();
        tick(); chk("rs_2",    4'h2, 1, 0, 0);
        tick(); chk("rs_done", 4'h2, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
